// File: rtl/handshake_fifo_buffer.sv
// handshake_fifo_buffer: opaque elastic FIFO stage for valid/ready dataflow.
// Tokens are stored in a circular buffer of DEPTH entries and leave in order.
// ins_ready, outs_valid and outs depend on registers only, so neither valid
// nor ready passes combinationally through the stage.
// Optional feature macro: HANDSHAKE_FIFO_BUFFER_COUNT_EN exposes the
// occupancy register on the `count` port.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         ins,
  input  logic                          ins_valid,
  output logic                          ins_ready,
  output logic [DATA_WIDTH-1:0]         outs,
  output logic                          outs_valid,
  input  logic                          outs_ready
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]    count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] OCC_FULL = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic                  push, pop;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake outputs come straight from state; no bypass in either direction.
  always_comb begin
    ins_ready  = (occ_q != OCC_FULL);
    outs_valid = (occ_q != '0);
    outs       = mem_q[rd_ptr_q];
    push       = ins_valid & ins_ready;
    pop        = outs_valid & outs_ready;
  end

  // Next-state for pointers and occupancy; simultaneous push/pop keeps occ.
  always_comb begin
    wr_ptr_d = push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (pop && !push) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  // Control state; reset discards every stored token immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage array; cleared on reset so outs reads zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= ins;
    end
  end

`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
  assign count = occ_q;
`endif

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Self-checking bench for handshake_fifo_buffer (DATA_WIDTH=6, DEPTH=4).
// A token queue with a capacity limit models the buffer; directed scenarios
// are followed by randomized valid/ready traffic.
module tb_handshake_fifo_buffer;

  localparam int DW = 6;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] ins;
  logic          ins_valid;
  logic          ins_ready;
  logic [DW-1:0] outs;
  logic          outs_valid;
  logic          outs_ready;
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
  logic [$clog2(DP+1)-1:0] count;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq[$];

  handshake_fifo_buffer #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .outs       (outs),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
    ,
    .count      (count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Compare DUT against the queue model, then advance one clock edge.
  task automatic step(input string tag);
    int n;
    bit do_push, do_pop;
    n = mq.size();
    chk({tag, "_outs_valid"}, 32'(outs_valid), 32'(n != 0));
    chk({tag, "_ins_ready"}, 32'(ins_ready), 32'(n != DP));
    if (n != 0) chk({tag, "_outs"}, 32'(outs), 32'(mq[0]));
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
    chk({tag, "_count"}, 32'(count), 32'(n));
`endif
    do_push = ins_valid && (n != DP);
    do_pop  = outs_ready && (n != 0);
    @(posedge clk);
    if (do_pop)  void'(mq.pop_front());
    if (do_push) mq.push_back(ins);
    #1;
  endtask

  initial begin
    rst        = 1'b0;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;

    // Power-on reset state.
    #12;
    chk("por_outs_valid", 32'(outs_valid), 32'd0);
    chk("por_ins_ready", 32'(ins_ready), 32'd1);
    chk("por_outs", 32'(outs), 32'd0);
    rst = 1'b1;

    // Single token latency.
    ins = 6'b010101; ins_valid = 1'b1; outs_ready = 1'b1;
    chk("lat_empty_valid", 32'(outs_valid), 32'd0);
    step("lat_push");
    ins_valid = 1'b0;
    chk("lat_outs", 32'(outs), 32'h15);
    chk("lat_valid", 32'(outs_valid), 32'd1);
    step("lat_pop");
    chk("lat_after_pop", 32'(outs_valid), 32'd0);

    // Fill and stall.
    outs_ready = 1'b0; ins_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      ins = DW'(i);
      step("fill");
    end
    chk("full_ins_ready", 32'(ins_ready), 32'd0);
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
    chk("full_count", 32'(count), 32'd4);
`endif
    ins = 6'd5;
    step("stall0");
    step("stall1");
    chk("stall_outs", 32'(outs), 32'd1);

    // Full with pop: no bypass, 5 enters one cycle later.
    outs_ready = 1'b1;
    chk("fpop_ins_ready", 32'(ins_ready), 32'd0);
    step("fpop");
    chk("fpop_recover", 32'(ins_ready), 32'd1);
    outs_ready = 1'b0;
    step("fpop_push5");
    ins_valid = 1'b0; outs_ready = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk("drain_order", 32'(outs), 32'(e));
      step("drain");
    end
    chk("drain_empty", 32'(outs_valid), 32'd0);

    // Wrap-around streaming.
    ins_valid = 1'b1; outs_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ins = DW'(i);
      if (i > 0) chk("stream_seq", 32'(outs), 32'(i - 1));
      step("stream");
    end
    ins_valid = 1'b0;
    chk("stream_last", 32'(outs), 32'd19);
    step("stream_tail");

    // Mid-stream asynchronous reset with 3 tokens stored.
    outs_ready = 1'b0; ins_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins = DW'(40 + i);
      step("prerst");
    end
    ins_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_outs_valid", 32'(outs_valid), 32'd0);
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("rst_outs", 32'(outs), 32'd0);
`ifdef HANDSHAKE_FIFO_BUFFER_COUNT_EN
    chk("rst_count", 32'(count), 32'd0);
`endif
    #1 rst = 1'b1;
    mq.delete();
    ins = 6'h2A; ins_valid = 1'b1;
    step("postrst_push");
    ins_valid = 1'b0; outs_ready = 1'b1;
    chk("postrst_first", 32'(outs), 32'h2A);
    step("postrst_pop");

    // Randomized traffic against the model.
    for (int c = 0; c < 1000; c++) begin
      ins        = DW'($urandom_range(0, 63));
      ins_valid  = 1'($urandom_range(0, 1));
      outs_ready = 1'($urandom_range(0, 1));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
